// File: rtl/sort_collector_if.sv
// Handshake bundle between the serial sorter, the collector and its downstream consumer.
// The slave modport is the collector's view; the master modport is the sorter/consumer side.
interface sort_collector_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
);
    localparam int CW = $clog2(DEPTH + 1);

    logic signed [WIDTH-1:0] data_serial_i;
    logic                    data_valid_i;
    logic                    ready_o;
    logic signed [WIDTH-1:0] rd_data_o;
    logic                    rd_valid_o;
    logic                    rd_ready_i;
    logic                    rd_last_o;
    logic                    done_o;
    logic                    sorted_ok_o;
    logic [CW-1:0]           count_o;
    logic                    drop_o;

    modport slave (
        input  data_serial_i, data_valid_i, rd_ready_i,
        output ready_o, rd_data_o, rd_valid_o, rd_last_o,
               done_o, sorted_ok_o, count_o, drop_o
    );

    modport master (
        output data_serial_i, data_valid_i, rd_ready_i,
        input  ready_o, rd_data_o, rd_valid_o, rd_last_o,
               done_o, sorted_ok_o, count_o, drop_o
    );
endinterface

// File: rtl/sort_collector.sv
// Captures one frame of DEPTH signed words from the serial sorter, checks the ordering on
// the fly, then replays the buffered frame to a consumer before accepting the next one.
module sort_collector #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 10,
    parameter bit ASCENDING = 1'b1
) (
    input logic             clk,
    input logic             rst,
    sort_collector_if.slave bus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic {CAPTURE, DRAIN} state_t;
    state_t state, next_state;

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic signed [WIDTH-1:0] prev;
    logic signed [WIDTH-1:0] word;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    ok_r;
    logic                    drop_r;
    logic                    done_r;
    logic                    accept;
    logic                    rd_take;
    logic                    offer_drop;
    logic                    last_wr;
    logic                    last_rd;
    logic                    violate;

    assign word = bus.data_serial_i;

    always_ff @(posedge clk) begin
        if (rst) state <= CAPTURE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        rd_take    = 1'b0;
        offer_drop = 1'b0;
        case (state)
            CAPTURE: begin
                accept = bus.data_valid_i;
                if (accept && wr_ptr == LAST) next_state = DRAIN;
            end
            DRAIN: begin
                rd_take    = bus.rd_ready_i;
                offer_drop = bus.data_valid_i;
                if (rd_take && rd_ptr == LAST) next_state = CAPTURE;
            end
            default: next_state = CAPTURE;
        endcase
    end

    assign last_wr = accept && (wr_ptr == LAST);
    assign last_rd = rd_take && (rd_ptr == LAST);
    // The first word of a frame has no predecessor, so it can never break the order.
    assign violate = (wr_ptr != '0) && (ASCENDING ? (word < prev) : (word > prev));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            prev   <= '0;
            ok_r   <= 1'b1;
            drop_r <= 1'b0;
            done_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            done_r <= last_wr;
            if (offer_drop) drop_r <= 1'b1;
            if (accept) begin
                mem[wr_ptr] <= word;
                prev        <= word;
                count       <= count + CW'(1);
                if (violate) ok_r <= 1'b0;
                // The write pointer parks on the last entry until the drain finishes.
                if (last_wr) rd_ptr <= '0;
                else         wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_take) begin
                if (last_rd) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                    ok_r   <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    assign bus.ready_o     = (state == CAPTURE);
    assign bus.rd_valid_o  = (state == DRAIN);
    assign bus.rd_data_o   = mem[rd_ptr];
    assign bus.rd_last_o   = (rd_ptr == LAST);
    assign bus.done_o      = done_r;
    assign bus.sorted_ok_o = ok_r;
    assign bus.count_o     = count;
    assign bus.drop_o      = drop_r;
endmodule

// File: doc/sort_collector.md
# sort_collector

Downstream stage of the serial sorter datapath. It accepts the sorter's serial output stream of `DEPTH` signed words under a valid/ready handshake and stores them in a local buffer. While capturing, it checks that the stream is monotonically ordered, then presents the stored words to a consumer through a valid/ready read port. It also flags ordering errors and words offered when it cannot accept them.

## Interface
Parameters:
- `WIDTH`, 32: data word width in bits, signed.
- `DEPTH`, 10: words per sorted frame; must be at least 2.
- `ASCENDING`, 1: 1 = each word must be ≥ its predecessor; 0 = each word must be ≤ its predecessor.

Ports (`CW` = `$clog2(DEPTH+1)`):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_serial_i`  in  WIDTH  signed word from the sorter.
- `data_valid_i`  in  1  `data_serial_i` is valid this cycle.
- `ready_o`  out  1  collector accepts a word this cycle.
- `rd_data_o`  out  WIDTH  signed buffered word at the read pointer.
- `rd_valid_o`  out  1  `rd_data_o` is valid.
- `rd_ready_i`  in  1  consumer takes `rd_data_o` this cycle.
- `rd_last_o`  out  1  the current read word is entry `DEPTH-1`.
- `done_o`  out  1  one-cycle pulse on entering DRAIN.
- `sorted_ok_o`  out  1  the captured frame was correctly ordered; meaningful only in DRAIN.
- `count_o`  out  CW  number of words captured in the current frame.
- `drop_o`  out  1  sticky: a word was offered while `ready_o` was 0.

## Operation
- States: CAPTURE and DRAIN. Reset state is CAPTURE.
- `ready_o` = (state == CAPTURE). `rd_valid_o` = (state == DRAIN). Both are decoded only from the state register.
- **CAPTURE:**
  - Accept condition: `data_valid_i && ready_o`.
  - On accept, write `buf[wr_ptr]`, increment `wr_ptr` and `count_o`, and load `prev` with the word.
  - From the second word of the frame onward, compare the word against `prev` using a signed compare.
  - If the order is violated (`word < prev` when `ASCENDING=1`; `word > prev` when `ASCENDING=0`), clear `ok_r`.
  - Equal words never violate order.
- **CAPTURE → DRAIN:** occurs on the accept of the `DEPTH`-th word (`wr_ptr == DEPTH-1`). Same edge:
  - `done_o` asserts for the next cycle only.
  - `rd_ptr` is set to 0.
  - `sorted_ok_o` is driven from `ok_r`, which includes the final comparison.
- **DRAIN:**
  - `rd_data_o` = `buf[rd_ptr]`.
  - `rd_last_o` = (`rd_ptr == DEPTH-1`).
  - On `rd_ready_i`, increment `rd_ptr`.
  - On `rd_ready_i && rd_last_o`, return to CAPTURE and clear `wr_ptr`, `count_o`, and `rd_ptr`. Set `ok_r` to 1.
  - `count_o` holds `DEPTH` throughout DRAIN.
- **Drop:** if `data_valid_i && !ready_o`, the word is discarded and `drop_o` sets.
  - `drop_o` clears only on `rst`.
  - A dropped word does not affect the buffer, the counters, or the order check.
- **Reset** (any state, mid-frame included): state goes to CAPTURE. `wr_ptr`, `rd_ptr`, `count_o`, and `prev` go to 0. `ok_r` goes to 1. `drop_o` and `done_o` go to 0. All `buf` entries go to 0. A partial frame is discarded.
- **Output reset values:**
  - `ready_o`=1, `rd_valid_o`=0, `rd_last_o`=0 (rd_ptr is 0).
  - `rd_data_o`=0, `done_o`=0, `sorted_ok_o`=1.
  - `count_o`=0, `drop_o`=0.
- **Width rules:**
  - Pointers are `$clog2(DEPTH)` bits and never exceed `DEPTH-1`; no wrap logic is needed beyond the clear.
  - Comparison is on the full `WIDTH` bits, signed.

## Timing
- A word accepted at edge N is readable at `buf` from cycle N+1.
- `count_o` updates at edge N.
- Last word accepted at edge N: state is DRAIN at N+1; `rd_valid_o`=1, `done_o`=1 (cycle N+1 only), and `sorted_ok_o` is final.
- Read-side throughput is one word per cycle when `rd_ready_i` is held high. With `rd_ready_i` held high from N+1, the frame drains by edge N+`DEPTH`, and `ready_o` is 1 again in cycle N+`DEPTH`+1.
- The earliest next-frame accept is cycle N+`DEPTH`+1. There is no overlap of capture and drain.
- With `rd_ready_i`=0, `rd_data_o`, `rd_valid_o`, and `rd_last_o` hold stable.
- `rst` has priority over every other event on the same edge.

## Test plan
- **Ascending frame:** feed -5, -3, 0, 0, 2, 7, 9, 11, 20, 100 on consecutive cycles with `rd_ready_i`=1 → `done_o` pulses once; `sorted_ok_o`=1; reads return the same 10 values in order; `rd_last_o` is high only on 100; `ready_o` returns to 1 after the 10th read.
- **Order violation and signed compare:** feed 1, 2, 3, -1 (0xFFFFFFFF), 4, 5, 6, 7, 8, 9 → `sorted_ok_o`=0. Repeat with `ASCENDING=0` and the sequence 9 down to 0 → `sorted_ok_o`=1.
- **Read backpressure and bubbles:** toggle `rd_ready_i` pseudo-randomly and insert gaps in `data_valid_i` → no word is lost or duplicated, and `rd_data_o` is stable while `rd_ready_i`=0.
- **Drop:** assert `data_valid_i` with value 42 during DRAIN → `drop_o`=1 and stays 1; the buffer and the next frame are unaffected.
- **Reset mid-capture:** accept 4 words, then assert `rst` for 1 cycle → `count_o`=0, `ready_o`=1, `sorted_ok_o`=1; a following full frame captures correctly.
- **Reset mid-drain:** reset after 3 reads → `rd_valid_o`=0, `rd_data_o`=0, `drop_o`=0.
